// File: rtl/mul_share_arbiter_if.sv
// Requester, response and multiplier-side signals of mul_share_arbiter, bundled as one interface.
// With MUL_ARB_STATS_EN defined, the per-requester grant counters are carried here too.
interface mul_share_arbiter_if;
  logic        req_valid_0;
  logic        req_ready_0;
  logic [46:0] req_a_0;
  logic [46:0] req_b_0;
  logic [47:0] req_c_0;
  logic        req_valid_1;
  logic        req_ready_1;
  logic [46:0] req_a_1;
  logic [46:0] req_b_1;
  logic [47:0] req_c_1;

  logic        rsp_valid_0;
  logic        rsp_ready_0;
  logic [95:0] rsp_data_0;
  logic        rsp_valid_1;
  logic        rsp_ready_1;
  logic [95:0] rsp_data_1;

  logic        mul_in_valid;
  logic [46:0] mul_in_1;
  logic [46:0] mul_in_2;
  logic [47:0] mul_in_3;
  logic        mul_out_valid;
  logic [95:0] mul_out;

  logic        err_orphan;
`ifdef MUL_ARB_STATS_EN
  logic [15:0] grant_cnt_0;
  logic [15:0] grant_cnt_1;
`endif

  modport slave (
    input  req_valid_0, req_a_0, req_b_0, req_c_0,
    input  req_valid_1, req_a_1, req_b_1, req_c_1,
    input  rsp_ready_0, rsp_ready_1, mul_out_valid, mul_out,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1,
    output mul_in_valid, mul_in_1, mul_in_2, mul_in_3,
`ifdef MUL_ARB_STATS_EN
    output grant_cnt_0, grant_cnt_1,
`endif
    output err_orphan
  );

  modport master (
    output req_valid_0, req_a_0, req_b_0, req_c_0,
    output req_valid_1, req_a_1, req_b_1, req_c_1,
    output rsp_ready_0, rsp_ready_1, mul_out_valid, mul_out,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1,
    input  mul_in_valid, mul_in_1, mul_in_2, mul_in_3,
`ifdef MUL_ARB_STATS_EN
    input  grant_cnt_0, grant_cnt_1,
`endif
    input  err_orphan
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between two credit-gated requesters.
// Define MUL_ARB_STATS_EN to add saturating 16-bit grant counters per requester.
module mul_share_arbiter #(
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  mul_share_arbiter_if.slave bus_io
);

  localparam int unsigned     PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       not_empty;
  logic [1:0][95:0] head;
`ifdef MUL_ARB_STATS_EN
  logic [1:0][15:0] gcnt;
`endif

  logic             last_q;
  logic [MUL_LAT:0] tag_vld_q;
  logic [MUL_LAT:0] tag_id_q;
  logic             tail_vld;
  logic             tail_id;
  logic             orphan;
  logic             mul_vld_q;
  logic [46:0]      mul_a_q;
  logic [46:0]      mul_b_q;
  logic [47:0]      mul_c_q;
  logic             err_q;

  assign req_valid = {bus_io.req_valid_1, bus_io.req_valid_0};
  assign rsp_ready = {bus_io.rsp_ready_1, bus_io.rsp_ready_0};

  // On a tie the requester not served last wins; last_q resets to 1 so requester 0 goes first.
  always_comb begin
    grant = 2'b00;
    if (elig[0] && (!elig[1] || last_q)) begin
      grant[0] = 1'b1;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
    end
  end

  // The oldest tag stage lines up with the multiplier output of the op it describes.
  assign tail_vld = tag_vld_q[MUL_LAT];
  assign tail_id  = tag_id_q[MUL_LAT];
  assign orphan   = bus_io.mul_out_valid && !tail_vld;
  assign push[0]  = bus_io.mul_out_valid && tail_vld && !tail_id;
  assign push[1]  = bus_io.mul_out_valid && tail_vld && tail_id;
  assign pop      = not_empty & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_c_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      mul_vld_q <= |grant;
      mul_a_q   <= grant[0] ? bus_io.req_a_0 : (grant[1] ? bus_io.req_a_1 : '0);
      mul_b_q   <= grant[0] ? bus_io.req_b_0 : (grant[1] ? bus_io.req_b_1 : '0);
      mul_c_q   <= grant[0] ? bus_io.req_c_0 : (grant[1] ? bus_io.req_c_1 : '0);
      if (|grant) begin
        last_q <= grant[1];
      end
      tag_vld_q <= {tag_vld_q[MUL_LAT-1:0], |grant};
      tag_id_q  <= {tag_id_q[MUL_LAT-1:0], grant[1]};
      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [95:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] credit_q;
    logic [CntW-1:0] credit_d;

    // Credits cover in-flight ops plus stored results, so a push never finds the FIFO full.
    assign elig[g]      = req_valid[g] && (credit_q < CntMax);
    assign not_empty[g] = (cnt_q != '0);
    assign head[g]      = not_empty[g] ? mem_q[rd_q] : '0;

    always_comb begin
      credit_d = credit_q;
      if (grant[g] && !pop[g]) begin
        credit_d = credit_q + CntW'(1);
      end else if (!grant[g] && pop[g]) begin
        credit_d = credit_q - CntW'(1);
      end
      cnt_d = cnt_q;
      if (push[g] && !pop[g]) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (!push[g] && pop[g]) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q     <= '0;
        rd_q     <= '0;
        cnt_q    <= '0;
        credit_q <= '0;
      end else begin
        cnt_q    <= cnt_d;
        credit_q <= credit_d;
        if (push[g]) begin
          wr_q <= (wr_q == PtrLast) ? '0 : wr_q + PtrW'(1);
        end
        if (pop[g]) begin
          rd_q <= (rd_q == PtrLast) ? '0 : rd_q + PtrW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem_q[wr_q] <= bus_io.mul_out;
      end
    end

`ifdef MUL_ARB_STATS_EN
    logic [15:0] gcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gcnt_q <= '0;
      end else if (grant[g] && (gcnt_q != 16'hFFFF)) begin
        gcnt_q <= gcnt_q + 16'd1;
      end
    end

    assign gcnt[g] = gcnt_q;
`endif
  end

  assign bus_io.req_ready_0  = grant[0];
  assign bus_io.req_ready_1  = grant[1];
  assign bus_io.rsp_valid_0  = not_empty[0];
  assign bus_io.rsp_valid_1  = not_empty[1];
  assign bus_io.rsp_data_0   = head[0];
  assign bus_io.rsp_data_1   = head[1];
  assign bus_io.mul_in_valid = mul_vld_q;
  assign bus_io.mul_in_1     = mul_a_q;
  assign bus_io.mul_in_2     = mul_b_q;
  assign bus_io.mul_in_3     = mul_c_q;
  assign bus_io.err_orphan   = err_q;
`ifdef MUL_ARB_STATS_EN
  assign bus_io.grant_cnt_0  = gcnt[0];
  assign bus_io.grant_cnt_1  = gcnt[1];
`endif

endmodule
